// File: rtl/arb_pkg.sv
// Shared types and constants for the 4-requester round-robin arbiter.
package arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;
    localparam int DATA_W  = 4;

    // Pointer starts at the last index so the first search begins at requester 0.
    localparam logic [IDX_W-1:0] PTR_RST = 2'd3;

    function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        return NUM_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/mux4x1_4b.sv
// 4-bit wide 4:1 data mux; {s1,s0} selects i0..i3.
module mux4x1_4b (
    input  logic [3:0] i0,
    input  logic [3:0] i1,
    input  logic [3:0] i2,
    input  logic [3:0] i3,
    input  logic       s0,
    input  logic       s1,
    output logic [3:0] f
);

    always_comb begin
        f = i0;
        case ({s1, s0})
            2'd0:    f = i0;
            2'd1:    f = i1;
            2'd2:    f = i2;
            default: f = i3;
        endcase
    end

endmodule

// File: rtl/rr_pick4.sv
// Circular first-set search over four request bits, starting just after ptr.
module rr_pick4
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);

    logic [IDX_W-1:0] cand;

    // Walk from the farthest candidate back to ptr+1 so the nearest hit wins.
    always_comb begin
        found = 1'b0;
        idx   = ptr;
        cand  = ptr;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = ptr + IDX_W'(k);
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter_4x1_4b.sv
// Round-robin owner control for the shared 4:1 data mux with registered result bus.
// Optional hold-time limit per owner is enabled with `define ARB_TIMEOUT_EN.
module rr_arbiter_4x1_4b
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [DATA_W-1:0] i0,
    input  logic [DATA_W-1:0] i1,
    input  logic [DATA_W-1:0] i2,
    input  logic [DATA_W-1:0] i3,
    output logic [NUM_REQ-1:0] gnt,
    output logic              s0,
    output logic              s1,
    output logic              busy,
    output logic [DATA_W-1:0] f
);

    if (MAX_HOLD < 1 || MAX_HOLD > 15) begin : g_max_hold_range
        $error("MAX_HOLD must be within 1..15");
    end

    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   sel_q, sel_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [DATA_W-1:0]  f_q, f_d;

    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic [DATA_W-1:0]  mux_out;
    logic               hold_expired;

`ifdef ARB_TIMEOUT_EN
    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);
    logic [3:0] hold_q, hold_d;
`endif

    rr_pick4 u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    mux4x1_4b u_mux (
        .i0 (i0),
        .i1 (i1),
        .i2 (i2),
        .i3 (i3),
        .s0 (sel_q[0]),
        .s1 (sel_q[1]),
        .f  (mux_out)
    );

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        ptr_d        = ptr_q;
        gnt_d        = gnt_q;
        hold_expired = 1'b0;
`ifdef ARB_TIMEOUT_EN
        hold_d       = 4'd0;
        hold_expired = (hold_q == HOLD_LAST) && (|(req & ~gnt_q));
`endif
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = GRANT;
                    sel_d   = pick_idx;
                    ptr_d   = pick_idx;
                    gnt_d   = idx_to_onehot(pick_idx);
                end
            end
            default: begin
                if (req[sel_q] && !hold_expired) begin
`ifdef ARB_TIMEOUT_EN
                    hold_d = (hold_q == HOLD_LAST) ? hold_q : hold_q + 4'd1;
`endif
                end else if (pick_found) begin
                    // ptr equals the owner here, so the search lands on someone else.
                    sel_d = pick_idx;
                    ptr_d = pick_idx;
                    gnt_d = idx_to_onehot(pick_idx);
                end else begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end
            end
        endcase

        // Result bus clears on the edge the grant drops so IDLE never shows stale data.
        f_d = ((state_q == GRANT) && (state_d == GRANT)) ? mux_out : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            ptr_q   <= PTR_RST;
            gnt_q   <= '0;
            f_q     <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            f_q     <= f_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= 4'd0;
        end else begin
            hold_q <= hold_d;
        end
    end
`endif

    assign gnt  = gnt_q;
    assign s0   = sel_q[0];
    assign s1   = sel_q[1];
    assign busy = (state_q == GRANT);
    assign f    = f_q;

endmodule

// File: tb/tb_rr_arbiter_4x1_4b.sv
// Directed bench for rr_arbiter_4x1_4b with a cycle-level reference model.
module tb_rr_arbiter_4x1_4b;

    localparam int MH = 4;
`ifdef ARB_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] i0, i1, i2, i3;
    logic [3:0] gnt;
    logic       s0, s1, busy;
    logic [3:0] f;

    int n_vec = 0;
    int n_bad = 0;

    rr_arbiter_4x1_4b #(.MAX_HOLD(MH)) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .i0   (i0),
        .i1   (i1),
        .i2   (i2),
        .i3   (i3),
        .gnt  (gnt),
        .s0   (s0),
        .s1   (s1),
        .busy (busy),
        .f    (f)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, want %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int search(input logic [3:0] r, input logic [1:0] p);
        for (int k = 1; k <= 4; k++) begin
            int j;
            j = (int'(p) + k) % 4;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    // Reference model: owner, pointer, busy flag, hold count and result bus.
    logic [1:0] m_owner;
    logic [1:0] m_ptr;
    logic       m_busy;
    int         m_hold;
    logic [3:0] m_f;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_owner <= 2'd0;
            m_ptr   <= 2'd3;
            m_busy  <= 1'b0;
            m_hold  <= 0;
            m_f     <= 4'd0;
        end else begin
            logic [3:0] dv [4];
            int         pick;
            bit         others, expire;
            dv     = '{i0, i1, i2, i3};
            pick   = search(req, m_ptr);
            others = (req & ~(4'b0001 << m_owner)) != 4'd0;
            if (!m_busy) begin
                m_f <= 4'd0;
                m_hold <= 0;
                if (pick >= 0) begin
                    m_busy  <= 1'b1;
                    m_owner <= 2'(pick);
                    m_ptr   <= 2'(pick);
                end
            end else begin
                expire = TMO && (m_hold == MH - 1) && others;
                if (req[m_owner] && !expire) begin
                    m_f    <= dv[m_owner];
                    m_hold <= (m_hold == MH - 1) ? m_hold : m_hold + 1;
                end else if (pick >= 0) begin
                    m_f     <= dv[m_owner];
                    m_owner <= 2'(pick);
                    m_ptr   <= 2'(pick);
                    m_hold  <= 0;
                end else begin
                    m_f    <= 4'd0;
                    m_busy <= 1'b0;
                    m_hold <= 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("gnt",  gnt, m_busy ? (4'b0001 << m_owner) : 4'b0000);
        chk("sel",  {2'b00, s1, s0}, {2'b00, m_owner});
        chk("busy", {3'b000, busy}, {3'b000, m_busy});
        chk("f",    f, m_f);
        chk("onehot", {3'b000, $onehot0(gnt)}, 4'b0001);
        chk("busy_eq_or_gnt", {3'b000, busy}, {3'b000, |gnt});
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_rst();
        #1 rst = 1'b1;
        #1 rst = 1'b0;
    endtask

    logic [3:0] rot [5];
    logic [3:0] tbl [12];

    initial begin
        rot = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        tbl = '{4'b0010, 4'b0110, 4'b0100, 4'b1001, 4'b1001, 4'b0000,
                4'b1000, 4'b0111, 4'b0101, 4'b0001, 4'b1010, 4'b0000};
        req = 4'b0000;
        i0 = 4'b1010; i1 = 4'b0011; i2 = 4'b0110; i3 = 4'b1100;
        rst = 1'b0;
        #1 rst = 1'b1;
        #3;
        chk("rst_gnt",  gnt, 4'b0000);
        chk("rst_busy", {3'b000, busy}, 4'b0000);
        chk("rst_f",    f, 4'b0000);
        chk("rst_sel",  {2'b00, s1, s0}, 4'b0000);
        @(posedge clk);
        #2 rst = 1'b0;

        req = 4'b0001;
        tick();
        chk("first_gnt",  gnt, 4'b0001);
        chk("first_sel",  {2'b00, s1, s0}, 4'b0000);
        chk("first_busy", {3'b000, busy}, 4'b0001);
        tick();
        chk("first_f", f, 4'b1010);

        for (int k = 0; k < 4; k++) begin
            req = 4'b1111 & ~rot[k];
            tick();
            chk("rotate_gnt",  gnt, rot[k+1]);
            chk("rotate_busy", {3'b000, busy}, 4'b0001);
        end

        req = 4'b0100;
        tick();
        chk("to_owner2", gnt, 4'b0100);
        tick();
        chk("owner2_f", f, 4'b0110);
        req = 4'b0000;
        tick();
        chk("release_gnt",  gnt, 4'b0000);
        chk("release_busy", {3'b000, busy}, 4'b0000);
        chk("release_f",    f, 4'b0000);
        req = 4'b0011;
        tick();
        chk("wrap_gnt", gnt, 4'b0001);

        req = 4'b0100;
        tick();
        chk("pre_rst_gnt", gnt, 4'b0100);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_gnt",  gnt, 4'b0000);
        chk("async_rst_busy", {3'b000, busy}, 4'b0000);
        chk("async_rst_f",    f, 4'b0000);
        @(negedge clk);
        #2 rst = 1'b0;
        req = 4'b1111;
        tick();
        chk("post_rst_gnt", gnt, 4'b0001);

`ifndef ARB_TIMEOUT_EN
        i0 = 4'b0111;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("hold_gnt", gnt, 4'b0001);
        end
        chk("hold_f", f, 4'b0111);
`else
        req = 4'b0011;
        pulse_rst();
        for (int k = 0; k < 12; k++) begin
            tick();
            chk("timeout_gnt", gnt, (((k / 4) % 2) == 0) ? 4'b0001 : 4'b0010);
        end
        req = 4'b0001;
        pulse_rst();
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("solo_gnt", gnt, 4'b0001);
        end
`endif

        for (int k = 0; k < 12; k++) begin
            req = tbl[k];
            i0 = 4'(k);
            i1 = 4'(k + 3);
            i2 = 4'(15 - k);
            i3 = 4'(k * 5);
            tick();
        end
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
